sba_mem_responder: RTL and testbench

Bus-side responder for the debug module's System Bus Access (SBA) master port: the other end of the `master_*` interface driven by `dm_sba_top`. It accepts single-word read/write requests, grants them (optionally after programmable wait states), and returns a registered response carrying read data or error flags. It serves as the on-chip SBA target RAM in the debug subsystem and as the reference slave in SBA benches.

---
 rtl/sba_mem_responder_if.sv | 28 ++
 rtl/sba_mem_responder.sv | 108 ++++++++++
 tb/tb_sba_mem_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sba_mem_responder_if.sv
// Request/response bus between an SBA master and the memory responder.
// Both sides attach through the master and slave modports.
interface sba_mem_responder_if;
    // The master raises req with add/we/wdata/be and holds them until it
    // sees gnt in the same cycle. The transaction transfers on req && gnt.
    // Exactly one cycle later r_valid pulses for one cycle, and
    // r_err/r_other_err/r_rdata are meaningful only in that cycle.
    logic        req;
    logic [31:0] add;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        r_valid;
    logic        r_err;
    logic        r_other_err;
    logic [31:0] r_rdata;

    modport master (
        output req, add, we, wdata, be,
        input  gnt, r_valid, r_err, r_other_err, r_rdata
    );

    modport slave (
        input  req, add, we, wdata, be,
        output gnt, r_valid, r_err, r_other_err, r_rdata
    );
endinterface

// File: rtl/sba_mem_responder.sv
// Single-word SBA target RAM with registered responses and decode errors.
// Define SBA_MEM_WAIT_EN to delay every grant by GNT_WAIT cycles.
module sba_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned GNT_WAIT    = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    sba_mem_responder_if.slave slave,
    output logic [1:0]         dbg_state
);
    localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    if (GNT_WAIT > 32'd65535) begin : g_gnt_wait_range
        $error("GNT_WAIT must fit in 16 bits");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   mem [0:DEPTH_WORDS-1];
    logic [31:0]   off;
    logic          oor;
    logic          null_acc;
    logic [AW-1:0] idx;
    logic          fire;

    assign off       = slave.add - BASE_ADDR;
    assign oor       = (slave.add < BASE_ADDR) || ({1'b0, off} >= LIMIT);
    assign null_acc  = (slave.be == 4'h0);
    assign idx       = off[AW+1:2];
    assign dbg_state = state;
    assign fire      = slave.gnt;

`ifdef SBA_MEM_WAIT_EN
    localparam int unsigned CW      = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
    localparam bit          NO_WAIT = (GNT_WAIT == 0);

    logic [CW-1:0] cnt;

    // The grant lands on the cycle in which the counter would hit zero.
    assign slave.gnt = rst_ni && slave.req &&
                       (((state != S_WAIT) && NO_WAIT) ||
                        ((state == S_WAIT) && (cnt == CW'(1))));
`else
    assign slave.gnt = rst_ni && slave.req && (state != S_WAIT);
`endif

    // Array is intentionally left without reset.
    always_ff @(posedge clk_i) begin
        if (fire && slave.we && !oor && !null_acc) begin
            for (int i = 0; i < 4; i++) begin
                if (slave.be[i]) begin
                    mem[idx][8*i +: 8] <= slave.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state             <= S_IDLE;
            slave.r_valid     <= 1'b0;
            slave.r_err       <= 1'b0;
            slave.r_other_err <= 1'b0;
            slave.r_rdata     <= 32'h0;
`ifdef SBA_MEM_WAIT_EN
            cnt               <= '0;
`endif
        end else begin
            slave.r_valid     <= fire;
            slave.r_err       <= fire && oor;
            slave.r_other_err <= fire && !oor && null_acc;
            slave.r_rdata     <= (fire && !oor && !null_acc && !slave.we) ? mem[idx] : 32'h0;
            case (state)
`ifdef SBA_MEM_WAIT_EN
                S_WAIT: begin
                    if (!slave.req) begin
                        state <= S_IDLE;
                    end else if (cnt == CW'(1)) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    if (!slave.req) begin
                        state <= S_IDLE;
                    end else if (NO_WAIT) begin
                        state <= S_RESP;
                    end else begin
                        cnt   <= CW'(GNT_WAIT);
                        state <= S_WAIT;
                    end
                end
`else
                default: state <= slave.req ? S_RESP : S_IDLE;
`endif
            endcase
        end
    end
endmodule

// File: tb/tb_sba_mem_responder.sv
// Randomized bench for sba_mem_responder with a word-array reference model
// and a cycle-stamped response scoreboard.
module tb_sba_mem_responder;
    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef SBA_MEM_WAIT_EN
    localparam int WAITC = 2;
`else
    localparam int WAITC = 0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  dbg_state;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    logic [31:0] exp_mem [DEPTH];
    logic [33:0] exp_q[$];
    int          due_q[$];
    logic        exp_v;
    logic [33:0] e;

    sba_mem_responder_if bus();

    sba_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .GNT_WAIT   (2)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .slave    (bus.slave),
        .dbg_state(dbg_state)
    );

    // Clock and cycle stamp
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: {r_err, r_other_err, rdata}
    function automatic logic [33:0] model_apply(input logic w, input logic [31:0] a,
                                                input logic [31:0] d, input logic [3:0] b);
        longint unsigned offs;
        int              idx;
        if (a < BASE) return {2'b10, 32'h0};
        offs = longint'(a) - longint'(BASE);
        if (offs >= 4 * longint'(DEPTH)) return {2'b10, 32'h0};
        if (b == 4'h0) return {2'b01, 32'h0};
        idx = int'(offs / 4);
        if (w) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) exp_mem[idx][8*i +: 8] = d[8*i +: 8];
            return {2'b00, 32'h0};
        end
        return {2'b00, exp_mem[idx]};
    endfunction

    // Driver: present one request, wait (bounded) for grant, log expected response.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input bit hold);
        int n;
        n = 0;
        bus.req = 1'b1; bus.we = w; bus.add = a; bus.wdata = d; bus.be = b;
        @(negedge clk);
        while (!bus.gnt && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("gnt_latency", n, WAITC);
        if (bus.gnt) begin
            exp_q.push_back(model_apply(w, a, d, b));
            due_q.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        if (!hold || !bus.gnt) bus.req = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
            check("r_valid", bus.r_valid, exp_v);
            if (!bus.req) check("gnt_without_req", bus.gnt, 1'b0);
            if (exp_v) begin
                e = exp_q.pop_front();
                void'(due_q.pop_front());
                check("r_err", bus.r_err, e[33]);
                check("r_other_err", bus.r_other_err, e[32]);
                check("r_rdata", bus.r_rdata, e[31:0]);
            end
        end
    end

    initial begin
        logic [31:0] a;
        bus.req = 1'b0; bus.we = 1'b0; bus.add = '0; bus.wdata = '0; bus.be = '0;

        // Reset state, with req raised to show gnt is held low in reset
        idle(2);
        bus.req = 1'b1; bus.add = 32'h10; bus.be = 4'hF;
        @(negedge clk);
        check("rst_gnt", bus.gnt, 1'b0);
        check("rst_r_valid", bus.r_valid, 1'b0);
        check("rst_r_err", bus.r_err, 1'b0);
        check("rst_r_other_err", bus.r_other_err, 1'b0);
        check("rst_r_rdata", bus.r_rdata, 32'h0);
        bus.req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Fill every word back-to-back so later reads are defined
        for (int i = 0; i < int'(DEPTH); i++)
            do_txn(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, i < int'(DEPTH) - 1);
        idle(1);

        // Full write then read
        do_txn(1'b1, 32'h10, 32'hABCD_ABCD, 4'hF, 1'b0);
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        // Partial write, unaligned read
        do_txn(1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF, 1'b0);
        do_txn(1'b1, 32'h14, 32'h1234_5678, 4'b0011, 1'b0);
        do_txn(1'b0, 32'h14, 32'h0, 4'hF, 1'b0);
        do_txn(1'b0, 32'h11, 32'h0, 4'hF, 1'b0);
        // Decode errors and null access
        do_txn(1'b0, 32'h400, 32'h0, 4'hF, 1'b0);
        do_txn(1'b1, 32'h20, 32'h5555_AAAA, 4'h0, 1'b0);
        do_txn(1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
        do_txn(1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0);
        do_txn(1'b0, 32'h3FF, 32'h0, 4'hF, 1'b0);
        // Back-to-back writes then reads with req held
        for (int i = 0; i < 4; i++)
            do_txn(1'b1, 32'(4 * i), 32'h1111_0000 + 32'(i), 4'hF, 1'b1);
        for (int i = 0; i < 4; i++)
            do_txn(1'b0, 32'(4 * i), 32'h0, 4'hF, i < 3);
        idle(2);

`ifdef SBA_MEM_WAIT_EN
        // Request withdrawn while waiting: no grant, no response
        bus.req = 1'b1; bus.we = 1'b0; bus.add = 32'h10; bus.be = 4'hF;
        @(negedge clk);
        check("wait_gnt_c0", bus.gnt, 1'b0);
        @(posedge clk); #1;
        bus.req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("wait_drop_gnt", bus.gnt, 1'b0);
        end
        idle(1);
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        idle(1);
`endif

        // Reset in the cycle after a grant drops the pending response
        do_txn(1'b0, 32'h14, 32'h0, 4'hF, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        due_q.delete();
        @(negedge clk);
        check("midrst_r_valid", bus.r_valid, 1'b0);
        check("midrst_gnt", bus.gnt, 1'b0);
        check("midrst_r_err", bus.r_err, 1'b0);
        check("midrst_r_other_err", bus.r_other_err, 1'b0);
        check("midrst_r_rdata", bus.r_rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        do_txn(1'b0, 32'h14, 32'h0, 4'hF, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 32'h43F));
            do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)));
            if (!bus.req) idle($urandom_range(0, 2));
        end
        bus.req = 1'b0;
        idle(5);
        check("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
